bit_packer: RTL and testbench
=============================

// Module: bit_packer
// PURPOSE
//  Packs variable-length Huffman codewords from jpeg_huffman_encode into a contiguous MSB-first
//  bitstream, emitted as 32-bit words. Sits between the Huffman encoder and the 32->8 width
//  adapter / byte stuffer in the jfpjc JPEG pipeline. Provides an end-of-image flush that pads
//  with 1s to a byte boundary, per JPEG.
// PARAMETERS
//  WORD_W   32  output word width; also the max codeword length
//  LEN_W    6   width of input_length
// PORTS
//  clock           in   1      single clock, all logic on posedge
//  nreset          in   1      reset; asynchronous, active-high (1 = in reset)
//  data_in_valid   in   1      codeword present this cycle
//  data_in         in   32     codeword, right-aligned; bits above input_length are ignored
//  input_length    in   6      codeword length in bits, 0..32
//  flush           in   1      1-cycle pulse: pad the partial word and emit it
//  data_out_valid  out  1      1-cycle strobe; data_out/data_out_bytes valid
//  data_out        out  32     packed bits; first stream bit at data_out[31]
//  data_out_bytes  out  3      count of valid leading bytes in data_out (4 except on flush)
// BEHAVIOUR
//  - Reset (async, while nreset=1): accumulator cleared, fill=0, flush_pend=0,
//    data_out_valid=0, data_out=0, data_out_bytes=0.
//  - No backpressure: a codeword is accepted on every cycle with data_in_valid=1.
//  - State: acc (63 bits), fill (0..31) = count of pending bits, left-aligned in acc.
//  - Accept: mask data_in to its low input_length bits; append them MSB-first after the
//    pending bits; new_fill = fill + len.
//  - If new_fill >= 32: next cycle data_out = first 32 pending bits, data_out_bytes=4,
//    data_out_valid=1. Keep the remaining new_fill-32 bits left-aligned; fill = new_fill-32.
//  - Latency: 1 cycle from the accepting edge to data_out_valid. Outputs are registered.
//  - input_length=0 with valid=1: no-op. input_length>32: clamp to 32.
//  - Flush with fill=0: no output. Flush with fill>0: pad 1s up to the next multiple of 8 bits
//    and fill the rest of the word with 1s. Emit next cycle with
//    data_out_bytes = ceil(fill/8) (1..4), data_out_valid=1. Then fill=0 and acc cleared.
//  - Flush and data_in_valid in the same cycle: accept the codeword first; set flush_pend.
//    Perform the flush on the next cycle unless that cycle accepts another codeword. Any
//    further codewords are appended before the deferred flush. At most one output word per cycle.
//  - data_out holds its last value when data_out_valid=0.
//  - Asserting reset mid-stream discards pending bits with no output.
// STRUCTURE
//  - Shared package jfpjc_pkg: WORD_W, LEN_W, and a function mask_low(len) giving the
//    codeword bit mask.
//  - Single module, no sub-modules. Shifting uses one barrel shifter (append position = fill).
// TESTING
//  - Reset: nreset=1 mid-stream -> data_out_valid=0, outputs 0. A flush right after reset
//    emits nothing.
//  - Exact word: 4 codewords, 0xAB/8 each -> one strobe, data_out=0xABABABAB, bytes=4.
//  - Straddle: 0x7/3 then 0x1FFFFFFF/29 then 0x0/4 -> first word 0xFFFFFFFF.
//    Flush then gives data_out[31:24]=0x0F and bytes=1.
//  - Flush pad: 0x5/3 (101) then flush -> data_out=0xBFFFFFFF, bytes=1.
//    0x1/9 then flush -> first byte 0x00, second byte 0xFF, bytes=2.
//  - Back-to-back: 1000 random codewords, one per cycle, lengths 0..32. The concatenated
//    output must match a scoreboard bitstream; fill stays < 32; at most 1 strobe per cycle.
//  - Same-cycle flush+valid: 0xF/4 with flush -> the next cycle is idle, the cycle after
//    emits 0xFFFFFFFF with bytes=1. Also check the 0-length and length>32 clamp cases.

Source files
------------

// File: rtl/jfpjc_pkg.sv
// Shared constants and helpers for the jfpjc bit packer.
// Word geometry plus the codeword mask helper.
package jfpjc_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 6;
  localparam int ACC_W  = 2 * WORD_W - 1;

  function automatic logic [WORD_W-1:0] mask_low(
    input logic [LEN_W-1:0] len
  );
    logic [WORD_W:0] m;
    m = ({{WORD_W{1'b0}}, 1'b1} << len) - 1'b1;
    return m[WORD_W-1:0];
  endfunction

endpackage

// File: rtl/bit_packer_if.sv
// Codeword input / packed word output bundle.
// The master drives codewords; the slave emits words.
interface bit_packer_if;
  import jfpjc_pkg::*;

  logic              data_in_valid;
  logic [WORD_W-1:0] data_in;
  logic [LEN_W-1:0]  input_length;
  logic              flush;
  logic              data_out_valid;
  logic [WORD_W-1:0] data_out;
  logic [2:0]        data_out_bytes;

  modport master (
    output data_in_valid,
    output data_in,
    output input_length,
    output flush,
    input  data_out_valid,
    input  data_out,
    input  data_out_bytes
  );

  modport slave (
    input  data_in_valid,
    input  data_in,
    input  input_length,
    input  flush,
    output data_out_valid,
    output data_out,
    output data_out_bytes
  );

endinterface

// File: rtl/bit_packer.sv
// MSB-first packer of variable-length codewords
// into 32-bit words, with a 1s-padded flush.
module bit_packer
  import jfpjc_pkg::*;
(
  input  logic        clock,
  input  logic        nreset,
  bit_packer_if.slave bus
);

  logic [ACC_W-1:0]  r_acc;
  logic [4:0]        r_fill;
  logic              r_pend;
  logic              r_valid;
  logic [WORD_W-1:0] r_out;
  logic [2:0]        r_bytes;

  logic [LEN_W-1:0]  w_len;
  logic [WORD_W-1:0] w_code;
  logic [5:0]        w_sh;
  logic [ACC_W-1:0]  w_ins;
  logic [ACC_W-1:0]  w_cat;
  logic [6:0]        w_sum;
  logic [5:0]        w_fp7;
  logic [WORD_W-1:0] w_pad;

  // Clamp, mask and barrel-shift the codeword
  // so its MSB lands just after the pending bits.
  always_comb begin
    w_len  = (bus.input_length > 6'd32) ?
             6'd32 : bus.input_length;
    w_code = bus.data_in & mask_low(w_len);
    w_sh   = 6'd63 - {1'b0, r_fill} - w_len;
    w_ins  = {{(ACC_W-WORD_W){1'b0}}, w_code}
             << w_sh;
    w_cat  = r_acc | w_ins;
    w_sum  = {2'b0, r_fill} + {1'b0, w_len};
    w_fp7  = {1'b0, r_fill} + 6'd7;
    w_pad  = r_acc[ACC_W-1 -: WORD_W]
           | ({WORD_W{1'b1}} >> r_fill);
  end

  // Accumulate, emit full words, and run
  // immediate or deferred flushes.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      r_acc   <= '0;
      r_fill  <= '0;
      r_pend  <= 1'b0;
      r_valid <= 1'b0;
      r_out   <= '0;
      r_bytes <= '0;
    end else begin
      r_valid <= 1'b0;
      if (bus.data_in_valid) begin
        r_fill <= w_sum[4:0];
        if (w_sum >= 7'd32) begin
          r_out   <= w_cat[ACC_W-1 -: WORD_W];
          r_bytes <= 3'd4;
          r_valid <= 1'b1;
          r_acc   <= w_cat << WORD_W;
        end else begin
          r_acc <= w_cat;
        end
        if (bus.flush) r_pend <= 1'b1;
      end else if (bus.flush || r_pend) begin
        r_pend <= 1'b0;
        if (r_fill != 5'd0) begin
          r_out   <= w_pad;
          r_bytes <= w_fp7[5:3];
          r_valid <= 1'b1;
        end
        r_acc  <= '0;
        r_fill <= '0;
      end
    end
  end

  assign bus.data_out_valid = r_valid;
  assign bus.data_out       = r_out;
  assign bus.data_out_bytes = r_bytes;

endmodule

// File: tb/tb_bit_packer.sv
// Directed and scoreboarded checks
// for the bit_packer block.
module tb_bit_packer;
  import jfpjc_pkg::*;

  logic clock = 1'b0;
  logic nreset = 1'b1;

  bit_packer_if bus();

  bit_packer dut (
    .clock  (clock),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  bit       mon_en = 1'b0;
  bit       q_out[$];
  bit       exp_q[$];
  int       n_strobe = 0;
  logic [2:0] last_bytes = 3'd0;

  task automatic chk(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic drive(
    input logic [31:0] d,
    input logic [5:0]  l,
    input logic        v,
    input logic        f
  );
    @(negedge clock);
    bus.data_in       = d;
    bus.input_length  = l;
    bus.data_in_valid = v;
    bus.flush         = f;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    drive(32'h0, 6'd0, 1'b0, 1'b0);
  endtask

  always @(posedge clock) begin
    #1;
    if (mon_en && bus.data_out_valid) begin
      n_strobe++;
      last_bytes = bus.data_out_bytes;
      for (int b = 0; b < 32; b++)
        if (b < 8 * int'(bus.data_out_bytes))
          q_out.push_back(bus.data_out[31-b]);
    end
  end

  initial begin
    logic [31:0] d;
    int l, total, rem, nwords, mism, nb;

    bus.data_in_valid = 1'b0;
    bus.data_in       = '0;
    bus.input_length  = '0;
    bus.flush         = 1'b0;

    #12;
    chk("reset_valid", bus.data_out_valid, 0);
    chk("reset_bytes", bus.data_out_bytes, 0);
    @(negedge clock);
    nreset = 1'b0;

    // exact word
    for (int i = 0; i < 3; i++) begin
      drive(32'hAB, 6'd8, 1'b1, 1'b0);
      chk("exact_idle", bus.data_out_valid, 0);
    end
    drive(32'hAB, 6'd8, 1'b1, 1'b0);
    chk("exact_valid", bus.data_out_valid, 1);
    chk("exact_data", bus.data_out, 32'hABABABAB);
    chk("exact_bytes", bus.data_out_bytes, 4);

    // reset mid-stream
    for (int i = 0; i < 3; i++)
      drive(32'hAB, 6'd8, 1'b1, 1'b0);
    idle();
    #2 nreset = 1'b1;
    #1;
    chk("rst_valid", bus.data_out_valid, 0);
    chk("rst_data", bus.data_out, 0);
    chk("rst_bytes", bus.data_out_bytes, 0);
    @(negedge clock);
    nreset = 1'b0;
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    chk("rst_flush", bus.data_out_valid, 0);
    idle();
    chk("rst_flush2", bus.data_out_valid, 0);

    // straddle
    drive(32'h7, 6'd3, 1'b1, 1'b0);
    chk("strad_idle", bus.data_out_valid, 0);
    drive(32'h1FFFFFFF, 6'd29, 1'b1, 1'b0);
    chk("strad_valid", bus.data_out_valid, 1);
    chk("strad_data", bus.data_out, 32'hFFFFFFFF);
    drive(32'h0, 6'd4, 1'b1, 1'b0);
    chk("strad_idle2", bus.data_out_valid, 0);
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    chk("strad_fvalid", bus.data_out_valid, 1);
    chk("strad_fbyte", bus.data_out[31:24], 8'h0F);
    chk("strad_fbytes", bus.data_out_bytes, 1);
    idle();
    chk("hold_valid", bus.data_out_valid, 0);
    chk("hold_data", bus.data_out, 32'h0FFFFFFF);

    // flush padding
    drive(32'h5, 6'd3, 1'b1, 1'b0);
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    chk("pad3_data", bus.data_out, 32'hBFFFFFFF);
    chk("pad3_bytes", bus.data_out_bytes, 1);
    drive(32'h1, 6'd9, 1'b1, 1'b0);
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    chk("pad9_valid", bus.data_out_valid, 1);
    chk("pad9_data", bus.data_out, 32'h00FFFFFF);
    chk("pad9_bytes", bus.data_out_bytes, 2);

    // same-cycle flush and codeword
    drive(32'hF, 6'd4, 1'b1, 1'b1);
    chk("same_idle", bus.data_out_valid, 0);
    idle();
    chk("same_valid", bus.data_out_valid, 1);
    chk("same_data", bus.data_out, 32'hFFFFFFFF);
    chk("same_bytes", bus.data_out_bytes, 1);
    idle();
    chk("same_after", bus.data_out_valid, 0);

    // deferred flush with an extra codeword
    drive(32'h3, 6'd2, 1'b1, 1'b1);
    drive(32'h0, 6'd2, 1'b1, 1'b0);
    chk("defer_idle", bus.data_out_valid, 0);
    idle();
    chk("defer_valid", bus.data_out_valid, 1);
    chk("defer_data", bus.data_out, 32'hCFFFFFFF);

    // zero length and masking
    drive(32'hFFFFFFFF, 6'd0, 1'b1, 1'b0);
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    chk("len0_flush", bus.data_out_valid, 0);
    drive(32'hFFFFFFF2, 6'd2, 1'b1, 1'b0);
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    chk("mask_data", bus.data_out, 32'hBFFFFFFF);

    // length clamp
    drive(32'h12345678, 6'd63, 1'b1, 1'b0);
    chk("clamp_valid", bus.data_out_valid, 1);
    chk("clamp_data", bus.data_out, 32'h12345678);
    chk("clamp_bytes", bus.data_out_bytes, 4);
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    chk("clamp_empty", bus.data_out_valid, 0);

    // random back-to-back stream
    q_out.delete();
    exp_q.delete();
    n_strobe = 0;
    mon_en = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      d = $urandom;
      l = $urandom_range(0, 32);
      for (int b = l - 1; b >= 0; b--)
        exp_q.push_back(d[b]);
      drive(d, 6'(l), 1'b1, 1'b0);
    end
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    idle();
    mon_en = 1'b0;
    total  = exp_q.size();
    rem    = total % 32;
    nwords = total / 32 + ((rem != 0) ? 1 : 0);
    nb     = (rem != 0) ? (rem + 7) / 8 : 4;
    while (exp_q.size() % 8 != 0)
      exp_q.push_back(1'b1);
    chk("rand_len", q_out.size(), exp_q.size());
    mism = 0;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= q_out.size() || q_out[i] != exp_q[i])
        mism++;
    chk("rand_bits", mism, 0);
    chk("rand_strobes", n_strobe, nwords);
    chk("rand_last_bytes", last_bytes, nb);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
